// File: rtl/tl_pkg.sv
// tl_pkg: TileLink-UL opcodes and the initiator state type, shared with the A-D responder.
package tl_pkg;
  localparam logic [2:0] GET = 3'd4;
  localparam logic [2:0] PUT_FULL = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] ARITH = 3'd2;
  localparam logic [2:0] LOGIC = 3'd3;
  localparam logic [2:0] INTENT = 3'd5;
  localparam logic [2:0] ACCESS_ACK = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] HINT_ACK = 3'd2;
  typedef enum logic [2:0] {IDLE, SEND_A, WAIT_D, REJECT, FAULT} state_t;
endpackage

// File: rtl/tilelink_ul_master_if.sv
// tilelink_ul_master_if: request/response side plus TileLink channels A and D.
interface tilelink_ul_master_if;
  logic req_valid, req_ready, req_write;
  logic [31:0] req_address, req_data;
  logic [3:0] req_size, req_mask;
  logic rsp_valid, rsp_ready, rsp_last, rsp_error, fault;
  logic [31:0] rsp_data;
  logic a_valid, a_ready, a_source;
  logic [2:0] a_opcode, a_param;
  logic [3:0] a_size, a_mask;
  logic [31:0] a_address, a_data;
  logic d_valid, d_ready, d_source, d_sink, d_error;
  logic [2:0] d_opcode;
  logic [1:0] d_param, d_addr_lo;
  logic [3:0] d_size;
  logic [31:0] d_data;
  modport master (
    input req_valid, req_write, req_address, req_size, req_mask, req_data, rsp_ready, a_ready,
          d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_addr_lo, d_data, d_error,
    output req_ready, rsp_valid, rsp_data, rsp_last, rsp_error, fault,
           a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready
  );
  modport slave (
    output req_valid, req_write, req_address, req_size, req_mask, req_data, rsp_ready, a_ready,
           d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_addr_lo, d_data, d_error,
    input req_ready, rsp_valid, rsp_data, rsp_last, rsp_error, fault,
          a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready
  );
endinterface

// File: rtl/tl_mask_gen.sv
// tl_mask_gen: byte-lane mask and 32-bit beat count for a transfer of 2**size bytes.
module tl_mask_gen (
  input  logic [3:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] mask,
  output logic [4:0] beats
);
  always_comb begin
    mask = size >= 4'd2 ? 4'hf : size == 4'd1 ? 4'b0011 << addr_lo : 4'b0001 << addr_lo;
    beats = size >= 4'd2 ? 5'd1 << (size - 4'd2) : 5'd1;
  end
endmodule

// File: rtl/tilelink_ul_master.sv
// tilelink_ul_master: single-outstanding TileLink-UL initiator with local reject and D-channel watchdog.
module tilelink_ul_master import tl_pkg::*; #(
  parameter logic SOURCE = 1'b0,
  parameter int MAX_SIZE = 6,
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input logic clock,
  input logic reset,
  tilelink_ul_master_if.master bus
);
  state_t state, state_n;
  logic write_q, bad, last, d_fire, unused_d;
  logic [31:0] addr_q, data_q;
  logic [3:0] size_q, mask_q, get_mask;
  logic [4:0] count, beats;
  logic [7:0] timer;
  tl_mask_gen u_mask (.size(size_q), .addr_lo(addr_q[1:0]), .mask(get_mask), .beats(beats));
  assign unused_d = ^{bus.d_param, bus.d_size, bus.d_sink, bus.d_addr_lo};
  always_comb begin
    bus.req_ready = state == IDLE && !reset;
    bus.a_valid = state == SEND_A;
    bus.d_ready = state == WAIT_D ? bus.rsp_ready : state == FAULT;
    bus.rsp_valid = state == WAIT_D ? bus.d_valid : state == REJECT;
    bus.rsp_data = state == WAIT_D && !write_q ? bus.d_data : 32'd0;
    last = count == beats - 5'd1;
    bus.rsp_last = state == WAIT_D ? last : state == REJECT;
    bus.rsp_error = state == WAIT_D ? bus.d_error || bus.d_source != SOURCE ||
                    bus.d_opcode != (write_q ? ACCESS_ACK : ACCESS_ACK_DATA) : state == REJECT;
    bus.fault = state == FAULT;
    bus.a_opcode = !write_q ? GET : mask_q == 4'hf ? PUT_FULL : PUT_PARTIAL;
    bus.a_param = 3'd0;
    bus.a_size = size_q;
    bus.a_source = SOURCE;
    bus.a_address = addr_q;
    bus.a_mask = write_q ? mask_q : get_mask;
    bus.a_data = data_q;
    d_fire = bus.d_valid && bus.d_ready;
    // oversize, wide Puts and misaligned addresses never reach channel A
    bad = bus.req_size > 4'(MAX_SIZE) || (bus.req_write && bus.req_size > 4'd2) ||
          (bus.req_address & ((32'd1 << bus.req_size) - 32'd1)) != 32'd0;
    state_n = state;
    if (state == IDLE && bus.req_valid) state_n = bad ? REJECT : SEND_A;
    if (state == SEND_A && bus.a_ready) state_n = WAIT_D;
    if (state == WAIT_D) state_n = d_fire ? (last ? IDLE : WAIT_D) : timer == TIMEOUT - 8'd1 ? FAULT : WAIT_D;
    if (state == REJECT && bus.rsp_ready) state_n = IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      count <= 5'd0;
      timer <= 8'd0;
      write_q <= 1'b0;
      addr_q <= 32'd0;
      data_q <= 32'd0;
      size_q <= 4'd0;
      mask_q <= 4'd0;
    end else begin
      state <= state_n;
      if (bus.req_ready && bus.req_valid) begin
        write_q <= bus.req_write;
        addr_q <= bus.req_address;
        data_q <= bus.req_data;
        size_q <= bus.req_size;
        mask_q <= bus.req_mask;
      end
      if (state == SEND_A) begin
        count <= 5'd0;
        timer <= 8'd0;
      end
      if (state == WAIT_D) begin
        count <= d_fire ? count + 5'd1 : count;
        timer <= d_fire ? 8'd0 : timer == TIMEOUT ? timer : timer + 8'd1;
      end
    end
  end
endmodule

// File: doc/tilelink_ul_master.md
# tilelink_ul_master

Single-outstanding TileLink-UL initiator for the Rocket formal harness. It turns a simple request/response interface into channel A Get/PutFullData/PutPartialData messages and collects channel D responses, streaming Get data back beat by beat. It sits opposite a TileLink A-D responder: bench stimulus or a bus-test driver on one side, a memory model or tile slave port on the other. Source ID is fixed, no B/C/E channels, and a response watchdog latches a fault.

## Interface
- SOURCE, 0: value driven on a_source; D beats must match it.
- MAX_SIZE, 6: largest legal log2 transfer size (64 B); larger sizes are rejected locally.
- TIMEOUT, 255: maximum cycles in WAIT_D without a D handshake before fault; 8-bit counter.
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid / req_ready  in/out  1  request handshake
- req_write  in  1  1 = Put, 0 = Get
- req_address  in  32  byte address
- req_size  in  4  log2 bytes
- req_mask  in  4  byte mask for Put; 4'hf gives PutFullData, otherwise PutPartialData
- req_data  in  32  Put data
- rsp_valid / rsp_ready  out/in  1  response beat handshake
- rsp_data  out  32  Get beat data; 0 for Put
- rsp_last  out  1  final beat of the transaction
- rsp_error  out  1  d_error, protocol mismatch, or local reject
- fault  out  1  sticky timeout indication, cleared only by reset
- a_valid, a_opcode[3], a_param[3], a_size[4], a_source[1], a_address[32], a_mask[4], a_data[32]  out  channel A
- a_ready  in  1
- d_valid, d_opcode[3], d_param[2], d_size[4], d_source[1], d_sink[1], d_addr_lo[2], d_data[32], d_error[1]  in  channel D
- d_ready  out  1

## Operation
- States: IDLE, SEND_A, WAIT_D, REJECT, FAULT.
- IDLE: req_ready=1. On accept, register the request and choose the next state:
  - REJECT if req_size > MAX_SIZE, if a Put has size > 2, or if the address is not aligned to the size.
  - SEND_A otherwise.
- SEND_A: a_valid=1 with all A fields held stable until a_ready. Opcodes are Get=4, PutFull=0, PutPartial=1; a_param=0.
  - Get a_mask: size ≥ 2 gives 4'hf; size 1 gives 4'b0011 << address[1:0]; size 0 gives 4'b0001 << address[1:0].
  - On the A handshake, go to WAIT_D, beat count = 0, timer = 0.
- WAIT_D: d_ready = rsp_ready and rsp_valid = d_valid, so D passes through to rsp combinationally.
  - Expected beats: (1 << size) / 4 for a Get with size ≥ 2, else 1.
  - rsp_last = (count == beats-1).
  - rsp_error = d_error, OR an opcode mismatch (Get expects AccessAckData=1, Put expects AccessAck=0), OR d_source ≠ SOURCE.
  - On each D handshake, count increments and timer clears. Handshake with last returns to IDLE.
  - Otherwise timer increments; when timer == TIMEOUT, go to FAULT.
- REJECT: rsp_valid=1, rsp_error=1, rsp_last=1, rsp_data=0. Return to IDLE on rsp_ready. No channel A traffic.
- FAULT: fault=1, req_ready=0, a_valid=0, d_ready=1 (drain and discard). Only reset exits.

## Timing
- Reset values: state IDLE; a_valid, d_ready, rsp_valid, rsp_last, rsp_error, fault all 0; req_ready 0 while reset is asserted; counters 0.
- Latency:
  - req accept to a_valid is 1 cycle.
  - A handshake to earliest D acceptance is 1 cycle; D is never accepted in the same cycle as the A handshake.
  - A 64 B Get yields 16 rsp beats, back-to-back when d_valid and rsp_ready are continuously high.
- req_ready is 0 from acceptance until the final rsp handshake, so only one transaction is ever in flight.
- The A payload must not change while a_valid=1 and a_ready=0.
- d_valid high in IDLE or SEND_A is ignored (d_ready=0); the verification bench asserts this never happens.
- A D beat with rsp_error set still counts toward the beat total; the transaction completes normally.
- Reset mid-transaction: return to IDLE next cycle and drop any outstanding response. The responder is reset together with this block.
- Widths: beat counter 5 bits (16 beats maximum); timer 8 bits, saturating at TIMEOUT.

## Structure
- Shared package tl_pkg: A opcode constants (GET, PUT_FULL, PUT_PARTIAL, ARITH, LOGIC, INTENT), D opcode constants (ACCESS_ACK, ACCESS_ACK_DATA, HINT_ACK), and a state enum typedef. The responder uses the same package.
- One sub-module, tl_mask_gen: combinational size/address to mask and beat-count. It is reused by the responder.
- FSM, beat counter and watchdog stay in the top module.

## Test plan
- Get, size 2, address 0x10000; D AccessAckData with data 0xDEADBEEF -> one rsp beat: data 0xDEADBEEF, last=1, error=0; a_mask 4'hf.
- Get, size 6, rsp_ready toggling every other cycle -> 16 beats, last only on the 16th; A fields stable while a_ready is held low for 3 cycles.
- Put, mask 4'b0110, data 0x12345678 -> a_opcode=1; D AccessAck -> rsp last=1, error=0, data=0.
- Put, size 3, or Get at address 0x10002 with size 2 -> REJECT response with error=1 and no a_valid ever.
- Get with a D beat that has d_source ≠ SOURCE or d_error=1 -> rsp_error=1 on that beat; transaction completes.
- D withheld for 255 cycles -> fault=1 and req_ready=0 until reset; reset asserted mid-Get -> a_valid=0 and IDLE next cycle.
